// File: rtl/pwm_cfg_commit_ctrl.sv
// Shadow/active register bank for the PWM core: SPI writes land in shadows and
// are copied to the active bank in one cycle at a period boundary, on force, or on timeout.
module pwm_cfg_commit_ctrl #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 8,
    parameter int NUM_REGS       = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         period_end,
    input  logic                         force_commit,
    output logic [NUM_REGS*DATA_W-1:0]   active_regs,
    output logic                         pending,
    output logic                         commit_pulse,
    output logic                         err_addr
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   timeout_cnt;
    logic [DATA_W-1:0]  shadow [NUM_REGS];
    logic               wr_fire;
    logic               addr_ok;
    logic               trigger;

    assign wr_fire = wr_valid && wr_ready;
    assign addr_ok = (wr_addr < ADDR_W'(NUM_REGS));
    assign trigger = period_end || force_commit ||
                     (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A write in the same cycle as a trigger still lands before COMMIT copies the shadows.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_fire && addr_ok) state_nxt = PENDING;
            PENDING: if (trigger)            state_nxt = COMMIT;
            COMMIT:                          state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state != COMMIT);
        pending  = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (state == PENDING) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end else begin
            timeout_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else if (wr_fire && addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_addr == ADDR_W'(i)) shadow[i] <= wr_data;
            end
        end
    end

    // Shadows are frozen during COMMIT (wr_ready=0), so the copy is atomic.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_regs <= '0;
        end else if (state == COMMIT) begin
            for (int i = 0; i < NUM_REGS; i++) active_regs[i*DATA_W +: DATA_W] <= shadow[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_pulse <= 1'b0;
            err_addr     <= 1'b0;
        end else begin
            commit_pulse <= (state == COMMIT);
            err_addr     <= wr_fire && !addr_ok;
        end
    end
endmodule
